counter_cmd_seq: RTL and testbench

- Command sequencer that drives the load/inc/dec/din control interface of the team's N-bit saturating up/down counter.
- Accepts high-level commands (load value, or step up/down a repeat count of times) over a valid/ready handshake.
- Expands each command into single-cycle control pulses toward the counter.
- Keeps a shadow copy of the expected count and flags any divergence from the counter's reported value.

---
 rtl/counter_cmd_seq.sv | 103 ++++++++++
 tb/tb_counter_cmd_seq.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_cmd_seq.sv
// Command sequencer for the saturating up/down counter: expands LOAD / INC xN / DEC xN
// commands into single-cycle control pulses and cross-checks the counter against a shadow copy.
module counter_cmd_seq #(
  parameter int N     = 8,
  parameter int REP_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [N-1:0]     cmd_data,
  input  logic [REP_W-1:0] cmd_rep,
  output logic             cnt_load,
  output logic             cnt_inc,
  output logic             cnt_dec,
  output logic [N-1:0]     cnt_din,
  input  logic [N-1:0]     cnt_count,
  output logic [N-1:0]     shadow,
  output logic             done,
  output logic             clipped,
  output logic             mismatch
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_FINISH} state_t;
  typedef enum logic [1:0] {OP_NOP, OP_LOAD, OP_INC, OP_DEC} op_t;

  localparam logic [N-1:0] CNT_MAX = '1;
  localparam logic [N-1:0] CNT_MIN = '0;

  state_t           state;
  op_t              op_q;
  logic [REP_W-1:0] remaining;
  logic [N-1:0]     din_q;
  logic [N-1:0]     shadow_q;
  logic             mismatch_q;
  logic             at_bound;

  // RUN is only ever entered with INC or DEC, so the bound test only needs those two cases.
  assign at_bound = (op_q == OP_INC) ? (shadow_q == CNT_MAX) : (shadow_q == CNT_MIN);

  // Every output is decoded from registers only; nothing combinational from cmd_* or cnt_count.
  assign cmd_ready = (state == S_IDLE);
  assign cnt_load  = (state == S_LOAD);
  assign cnt_inc   = (state == S_RUN) && (op_q == OP_INC) && !at_bound;
  assign cnt_dec   = (state == S_RUN) && (op_q == OP_DEC) && !at_bound;
  assign clipped   = (state == S_RUN) && at_bound;
  assign done      = (state == S_FINISH);
  assign cnt_din   = din_q;
  assign shadow    = shadow_q;
  assign mismatch  = mismatch_q;

  // NOTE: all state uses non-blocking assignments and the asynchronous reset clears every
  // register, so an in-flight command is dropped the instant reset rises.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      op_q       <= OP_NOP;
      remaining  <= '0;
      din_q      <= '0;
      shadow_q   <= '0;
      mismatch_q <= 1'b0;
    end else begin
      // Case inequality so an X/Z on cnt_count also counts as divergence; sticky until reset.
      if (cnt_count !== shadow_q) mismatch_q <= 1'b1;

      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            op_q      <= op_t'(cmd_op);
            remaining <= cmd_rep;
            case (op_t'(cmd_op))
              OP_LOAD: begin
                din_q <= cmd_data;
                state <= S_LOAD;
              end
              OP_INC, OP_DEC: state <= (cmd_rep != '0) ? S_RUN : S_FINISH;
              default:        state <= S_FINISH;
            endcase
          end
        end
        S_LOAD: begin
          shadow_q <= din_q;
          state    <= S_FINISH;
        end
        S_RUN: begin
          if (at_bound) begin
            // Saturated: the rest of the command is abandoned.
            remaining <= '0;
            state     <= S_FINISH;
          end else begin
            shadow_q  <= (op_q == OP_INC) ? shadow_q + N'(1) : shadow_q - N'(1);
            remaining <= remaining - REP_W'(1);
            if (remaining == REP_W'(1)) state <= S_FINISH;
          end
        end
        S_FINISH: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_counter_cmd_seq.sv
// Self-checking bench for counter_cmd_seq: directed vector table, reset/mismatch sequences,
// and random commands checked against an arithmetic per-command reference model.
module tb_counter_cmd_seq;
  localparam int N     = 8;
  localparam int REP_W = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [N-1:0]     cmd_data;
  logic [REP_W-1:0] cmd_rep;
  logic             cnt_load, cnt_inc, cnt_dec;
  logic [N-1:0]     cnt_din;
  logic [N-1:0]     cnt_count;
  logic [N-1:0]     shadow;
  logic             done, clipped, mismatch;

  counter_cmd_seq #(.N(N), .REP_W(REP_W)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .cmd_rep(cmd_rep),
    .cnt_load(cnt_load), .cnt_inc(cnt_inc), .cnt_dec(cnt_dec), .cnt_din(cnt_din),
    .cnt_count(cnt_count), .shadow(shadow),
    .done(done), .clipped(clipped), .mismatch(mismatch)
  );

  always #5 clk = ~clk;

  // Behavioural saturating counter driven by the sequencer; the bench can override its output.
  logic [N-1:0] ctr;
  logic         force_en;
  logic [N-1:0] force_val;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                         ctr <= '0;
    else if (cnt_load)                 ctr <= cnt_din;
    else if (cnt_inc && ctr != 8'hFF)  ctr <= ctr + 8'd1;
    else if (cnt_dec && ctr != 8'h00)  ctr <= ctr - 8'd1;
  end

  assign cnt_count = force_en ? force_val : ctr;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0] op;
    logic [7:0] data;
    int         rep;
    int         e_inc;
    int         e_dec;
    int         e_clip;
    int         e_cyc;
    logic [7:0] e_sh;
  } vec_t;

  typedef struct {
    int         n_inc;
    int         n_dec;
    int         n_clip;
    int         cycles;
    logic [7:0] sh;
  } result_t;

  logic [7:0] model_shadow;
  logic [7:0] last_load;
  logic       exp_mm;

  // Reference: steps issued = repeat count limited by headroom to the bound; a clip cycle
  // exists whenever the request exceeded that headroom.
  function automatic result_t predict(input logic [1:0] op, input logic [7:0] data,
                                      input int rep, input logic [7:0] s);
    result_t r;
    int room, k;
    r.n_inc = 0; r.n_dec = 0; r.n_clip = 0; r.cycles = 1; r.sh = s;
    case (op)
      2'd1: begin r.sh = data; r.cycles = 2; end
      2'd2, 2'd3: begin
        room     = (op == 2'd2) ? 255 - int'(s) : int'(s);
        k        = (rep < room) ? rep : room;
        r.n_clip = (rep > k) ? 1 : 0;
        r.cycles = k + r.n_clip + 1;
        if (op == 2'd2) begin r.n_inc = k; r.sh = 8'(int'(s) + k); end
        else            begin r.n_dec = k; r.sh = 8'(int'(s) - k); end
      end
      default: ;
    endcase
    return r;
  endfunction

  task automatic issue(input logic [1:0] op, input logic [7:0] data, input int rep);
    int w = 0;
    while (!cmd_ready && w < 50) begin @(negedge clk); w++; end
    check("ready_before_cmd", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_data = data; cmd_rep = REP_W'(rep);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_op    = 2'($urandom);
    cmd_data  = 8'($urandom);
    cmd_rep   = 8'($urandom);
  endtask

  task automatic apply(input string name, input logic [1:0] op, input logic [7:0] data,
                       input int rep, input int e_inc, input int e_dec, input int e_clip,
                       input int e_cyc, input logic [7:0] e_sh);
    int n_inc = 0, n_dec = 0, n_clip = 0, n_load = 0, cycles = 0, ready_hi = 0, excl = 0;
    logic [7:0] din_seen = 8'h00;
    issue(op, data, rep);
    do begin
      @(negedge clk);
      cycles++;
      n_inc  += int'(cnt_inc);
      n_dec  += int'(cnt_dec);
      n_clip += int'(clipped);
      n_load += int'(cnt_load);
      if (cnt_load) din_seen = cnt_din;
      if (cmd_ready) ready_hi++;
      if (int'(cnt_load) + int'(cnt_inc) + int'(cnt_dec) > 1) excl++;
    end while (!done && cycles < 400);
    check({name, ".inc_pulses"}, n_inc, e_inc);
    check({name, ".dec_pulses"}, n_dec, e_dec);
    check({name, ".clipped"},    n_clip, e_clip);
    check({name, ".latency"},    cycles, e_cyc);
    check({name, ".busy_ready"}, ready_hi, 0);
    check({name, ".exclusive"},  excl, 0);
    check({name, ".shadow"},     shadow, e_sh);
    check({name, ".load_pulses"}, n_load, (op == 2'd1) ? 1 : 0);
    if (op == 2'd1) begin
      check({name, ".load_din"}, din_seen, data);
      last_load = data;
    end
    model_shadow = e_sh;
    @(negedge clk);
    check({name, ".done_1cyc"}, done, 0);
    check({name, ".ready_after"}, cmd_ready, 1);
    check({name, ".counter"}, cnt_count, e_sh);
    check({name, ".din_hold"}, cnt_din, last_load);
    check({name, ".mismatch"}, mismatch, exp_mm);
  endtask

  task automatic apply_model(input string name, input logic [1:0] op, input logic [7:0] data,
                             input int rep);
    result_t r;
    r = predict(op, data, rep, model_shadow);
    apply(name, op, data, rep, r.n_inc, r.n_dec, r.n_clip, r.cycles, r.sh);
  endtask

  task automatic pulse_reset();
    #2 reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_shadow = 8'h00;
    last_load    = 8'h00;
    exp_mm       = 1'b0;
  endtask

  vec_t vecs[12];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{2'd1, 8'h10, 0,   0, 0, 0, 2,   8'h10};
    vecs[1]  = '{2'd2, 8'h00, 5,   5, 0, 0, 6,   8'h15};
    vecs[2]  = '{2'd1, 8'hFD, 0,   0, 0, 0, 2,   8'hFD};
    vecs[3]  = '{2'd2, 8'h00, 10,  2, 0, 1, 4,   8'hFF};
    vecs[4]  = '{2'd1, 8'h01, 0,   0, 0, 0, 2,   8'h01};
    vecs[5]  = '{2'd3, 8'h00, 3,   0, 1, 1, 3,   8'h00};
    vecs[6]  = '{2'd2, 8'h00, 0,   0, 0, 0, 1,   8'h00};
    vecs[7]  = '{2'd0, 8'h55, 7,   0, 0, 0, 1,   8'h00};
    vecs[8]  = '{2'd3, 8'h00, 2,   0, 0, 1, 2,   8'h00};
    vecs[9]  = '{2'd2, 8'h00, 255, 255, 0, 0, 256, 8'hFF};
    vecs[10] = '{2'd1, 8'h80, 0,   0, 0, 0, 2,   8'h80};
    vecs[11] = '{2'd3, 8'h00, 1,   0, 1, 0, 2,   8'h7F};

    cmd_valid = 1'b0; cmd_op = 2'd0; cmd_data = '0; cmd_rep = '0;
    force_en = 1'b0; force_val = '0;
    model_shadow = 8'h00; last_load = 8'h00; exp_mm = 1'b0;

    reset = 1'b1;
    #12;
    check("rst.shadow",   shadow, 8'h00);
    check("rst.cnt_pulses", {cnt_load, cnt_inc, cnt_dec}, 3'b000);
    check("rst.cnt_din",  cnt_din, 8'h00);
    check("rst.done_clip", {done, clipped}, 2'b00);
    check("rst.mismatch", mismatch, 0);
    check("rst.ready",    cmd_ready, 1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 12; i++)
      apply($sformatf("vec%0d", i), vecs[i].op, vecs[i].data, vecs[i].rep,
            vecs[i].e_inc, vecs[i].e_dec, vecs[i].e_clip, vecs[i].e_cyc, vecs[i].e_sh);

    // Reset in the middle of INC rep=20 after four pulses.
    begin
      int seen = 0, w = 0;
      issue(2'd2, 8'h00, 20);
      while (seen < 4 && w < 40) begin
        @(negedge clk); w++;
        seen += int'(cnt_inc);
      end
      check("midrst.pulses_before", seen, 4);
      #2 reset = 1'b1;
      #1;
      check("midrst.cnt_pulses", {cnt_load, cnt_inc, cnt_dec}, 3'b000);
      check("midrst.done_clip", {done, clipped}, 2'b00);
      check("midrst.shadow", shadow, 8'h00);
      check("midrst.cnt_din", cnt_din, 8'h00);
      check("midrst.mismatch", mismatch, 0);
      @(negedge clk);
      reset = 1'b0;
      model_shadow = 8'h00; last_load = 8'h00; exp_mm = 1'b0;
      @(negedge clk);
      check("midrst.ready_after", cmd_ready, 1);
      apply("after_rst_load", 2'd1, 8'h33, 0, 0, 0, 0, 2, 8'h33);
    end

    // Counter diverges from shadow: mismatch latches and survives later good cycles.
    force_en = 1'b1; force_val = 8'h44;
    @(negedge clk);
    force_en = 1'b0;
    check("mm.value_set", mismatch, 1);
    check("mm.shadow_kept", shadow, 8'h33);
    exp_mm = 1'b1;
    apply_model("mm.sticky_inc", 2'd2, 8'h00, 2);
    apply_model("mm.sticky_load", 2'd1, 8'h33, 0);
    pulse_reset();
    @(negedge clk);
    check("mm.cleared", mismatch, 0);
    apply("mm.reload", 2'd1, 8'h33, 0, 0, 0, 0, 2, 8'h33);
    force_en = 1'b1; force_val = 8'hxx;
    @(negedge clk);
    force_en = 1'b0;
    check("mm.x_set", mismatch, 1);
    repeat (3) @(negedge clk);
    check("mm.x_sticky", mismatch, 1);
    pulse_reset();
    @(negedge clk);

    // Random commands, with load values biased toward both bounds to exercise clipping.
    for (int i = 0; i < 60; i++) begin
      logic [1:0] op;
      logic [7:0] data;
      int rep;
      op = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 2))
        0:       data = 8'($urandom_range(0, 3));
        1:       data = 8'($urandom_range(252, 255));
        default: data = 8'($urandom);
      endcase
      rep = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255))
                                        : int'($urandom_range(0, 12));
      apply_model($sformatf("rnd%0d", i), op, data, rep);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
